// File: rtl/retire_stage.sv
// rtl/retire_stage.sv - in-order ROB-head commit with mispredict flush and terminal halt
// Optional RETIRE_CNT_EN adds a saturating retired-instruction counter on retire_cnt.
module retire_stage #(
  parameter int TAG_W  = 6,
  parameter int ARCH_W = 5,
  parameter int XLEN   = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rob_head_valid,
  input  logic              rob_head_done,
  input  logic [TAG_W-1:0]  rob_head_t,
  input  logic [TAG_W-1:0]  rob_head_told,
  input  logic [ARCH_W-1:0] rob_head_arch,
  input  logic              rob_head_mispred,
  input  logic              rob_head_halt,
  input  logic [XLEN-1:0]   rob_head_npc,
  output logic              rob_retire,
  output logic              arch_we,
  output logic [ARCH_W-1:0] arch_idx,
  output logic [TAG_W-1:0]  arch_tag,
  output logic              fl_free_valid,
  output logic [TAG_W-1:0]  fl_free_tag,
  output logic              flush,
  output logic [XLEN-1:0]   flush_pc,
`ifdef RETIRE_CNT_EN
  output logic [CNT_W-1:0]  retire_cnt,
`endif
  output logic              halted
);

  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_e;

  state_e            state_q, state_d;
  logic              arch_we_q, arch_we_d;
  logic [ARCH_W-1:0] arch_idx_q, arch_idx_d;
  logic [TAG_W-1:0]  arch_tag_q, arch_tag_d;
  logic              fl_free_valid_q, fl_free_valid_d;
  logic [TAG_W-1:0]  fl_free_tag_q, fl_free_tag_d;
  logic              flush_q, flush_d;
  logic [XLEN-1:0]   flush_pc_q, flush_pc_d;
  logic              halted_q, halted_d;
  logic              commit;

  // Gated by reset so a held-low reset never pops the ROB.
  assign commit     = reset && (state_q == RUN) && rob_head_valid && rob_head_done;
  assign rob_retire = commit;

  always_comb begin
    state_d         = state_q;
    arch_we_d       = 1'b0;
    arch_idx_d      = arch_idx_q;
    arch_tag_d      = arch_tag_q;
    fl_free_valid_d = 1'b0;
    fl_free_tag_d   = fl_free_tag_q;
    flush_d         = 1'b0;
    flush_pc_d      = flush_pc_q;
    halted_d        = halted_q;
    case (state_q)
      RUN: begin
        if (commit) begin
          if (rob_head_arch != '0) begin
            arch_we_d       = 1'b1;
            arch_idx_d      = rob_head_arch;
            arch_tag_d      = rob_head_t;
            fl_free_valid_d = 1'b1;
            fl_free_tag_d   = rob_head_told;
          end
          // Halt takes priority: a halting mispredict never redirects.
          if (rob_head_halt) begin
            state_d  = HALT;
            halted_d = 1'b1;
          end else if (rob_head_mispred) begin
            state_d    = FLUSH;
            flush_d    = 1'b1;
            flush_pc_d = rob_head_npc;
          end
        end
      end
      FLUSH:   state_d = RUN;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= RUN;
      arch_we_q       <= 1'b0;
      arch_idx_q      <= '0;
      arch_tag_q      <= '0;
      fl_free_valid_q <= 1'b0;
      fl_free_tag_q   <= '0;
      flush_q         <= 1'b0;
      flush_pc_q      <= '0;
      halted_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      arch_we_q       <= arch_we_d;
      arch_idx_q      <= arch_idx_d;
      arch_tag_q      <= arch_tag_d;
      fl_free_valid_q <= fl_free_valid_d;
      fl_free_tag_q   <= fl_free_tag_d;
      flush_q         <= flush_d;
      flush_pc_q      <= flush_pc_d;
      halted_q        <= halted_d;
    end
  end

  assign arch_we       = arch_we_q;
  assign arch_idx      = arch_idx_q;
  assign arch_tag      = arch_tag_q;
  assign fl_free_valid = fl_free_valid_q;
  assign fl_free_tag   = fl_free_tag_q;
  assign flush         = flush_q;
  assign flush_pc      = flush_pc_q;
  assign halted        = halted_q;

`ifdef RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (commit && (retire_cnt_q != '1)) retire_cnt_d = retire_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) retire_cnt_q <= '0;
    else        retire_cnt_q <= retire_cnt_d;
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_retire_stage.sv
// tb/tb_retire_stage.sv - randomized bench for retire_stage against a commit-rule model
// Exercises the RETIRE_CNT_EN counter (CNT_W=4) when that macro is defined.
module tb_retire_stage;

`ifdef RETIRE_CNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 32;
`endif
  localparam int M_RUN = 0, M_FLUSH = 1, M_HALT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rob_head_valid = 1'b1, rob_head_done = 1'b1;
  logic [5:0]  rob_head_t = '0, rob_head_told = '0;
  logic [4:0]  rob_head_arch = '0;
  logic        rob_head_mispred = 1'b0, rob_head_halt = 1'b0;
  logic [31:0] rob_head_npc = '0;
  logic        rob_retire, arch_we, fl_free_valid, flush, halted;
  logic [4:0]  arch_idx;
  logic [5:0]  arch_tag, fl_free_tag;
  logic [31:0] flush_pc;
`ifdef RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt;
`endif

  retire_stage #(.TAG_W(6), .ARCH_W(5), .XLEN(32), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .rob_head_valid(rob_head_valid), .rob_head_done(rob_head_done),
    .rob_head_t(rob_head_t), .rob_head_told(rob_head_told),
    .rob_head_arch(rob_head_arch), .rob_head_mispred(rob_head_mispred),
    .rob_head_halt(rob_head_halt), .rob_head_npc(rob_head_npc),
    .rob_retire(rob_retire), .arch_we(arch_we), .arch_idx(arch_idx),
    .arch_tag(arch_tag), .fl_free_valid(fl_free_valid), .fl_free_tag(fl_free_tag),
    .flush(flush), .flush_pc(flush_pc),
`ifdef RETIRE_CNT_EN
    .retire_cnt(retire_cnt),
`endif
    .halted(halted)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  int          mode = M_RUN;
  logic        e_we = 0, e_fv = 0, e_flush = 0, e_halted = 0;
  logic [4:0]  e_idx = 0;
  logic [5:0]  e_tag = 0, e_ftag = 0;
  logic [31:0] e_pc = 0;
  int          e_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle: verify registered outputs from the last edge, apply a head, verify rob_retire, advance the model.
  task automatic step(input logic r, input logic v, input logic d, input logic [5:0] t,
                      input logic [5:0] told, input logic [4:0] a, input logic mp,
                      input logic h, input logic [31:0] npc);
    logic exp_ret;
    @(negedge clock);
    check("arch_we", arch_we, e_we);
    if (e_we) begin
      check("arch_idx", arch_idx, e_idx);
      check("arch_tag", arch_tag, e_tag);
    end
    check("fl_free_valid", fl_free_valid, e_fv);
    if (e_fv) check("fl_free_tag", fl_free_tag, e_ftag);
    check("flush", flush, e_flush);
    if (e_flush) check("flush_pc", flush_pc, e_pc);
    check("halted", halted, e_halted);
`ifdef RETIRE_CNT_EN
    check("retire_cnt", retire_cnt, e_cnt);
`endif
    reset = r; rob_head_valid = v; rob_head_done = d; rob_head_t = t; rob_head_told = told;
    rob_head_arch = a; rob_head_mispred = mp; rob_head_halt = h; rob_head_npc = npc;
    #1;
    exp_ret = r && (mode == M_RUN) && v && d;
    check("rob_retire", rob_retire, exp_ret);
    if (!r) begin
      check("rst_halted", halted, 0);
      check("rst_flush", flush, 0);
      check("rst_arch_we", arch_we, 0);
      mode = M_RUN; e_we = 0; e_fv = 0; e_flush = 0; e_halted = 0; e_pc = 0; e_cnt = 0;
    end else begin
      if (mode == M_FLUSH) mode = M_RUN;
      e_we = exp_ret && (a != 0); e_fv = e_we; e_idx = a; e_tag = t; e_ftag = told;
      e_flush = 0;
      if (exp_ret) begin
        if (e_cnt < (1 << CNT_W) - 1) e_cnt++;
        if (h) begin
          mode = M_HALT; e_halted = 1;
        end else if (mp) begin
          mode = M_FLUSH; e_flush = 1; e_pc = npc;
        end
      end
    end
  endtask

  initial begin
    step(0, 1, 1, 6'h12, 6'h05, 5'd3, 0, 0, 32'h0);
    step(0, 1, 1, 6'h12, 6'h05, 5'd3, 1, 1, 32'h0);
    // Plain commit, then no-destination commit.
    step(1, 1, 1, 6'h12, 6'h05, 5'd3, 0, 0, 32'h0);
    step(1, 1, 1, 6'h21, 6'h07, 5'd0, 0, 0, 32'h0);
    step(1, 0, 0, 6'h00, 6'h00, 5'd0, 0, 0, 32'h0);
    // Stall on not-done head.
    step(1, 1, 0, 6'h22, 6'h08, 5'd4, 1, 0, 32'h0);
    // Mispredict then flush cycle with a ready head that must wait.
    step(1, 1, 1, 6'h23, 6'h09, 5'd5, 1, 0, 32'h400);
    step(1, 1, 1, 6'h24, 6'h0a, 5'd6, 0, 0, 32'h0);
    step(1, 1, 1, 6'h24, 6'h0a, 5'd6, 0, 0, 32'h0);
    // Halt with mispredict: no flush, never retires again.
    step(1, 1, 1, 6'h25, 6'h0b, 5'd7, 1, 1, 32'h800);
    for (int i = 0; i < 4; i++) step(1, 1, 1, 6'h26, 6'h0c, 5'd8, 0, 0, 32'h0);
    check("halted_direct", halted, 1);
    check("flush_direct", flush, 0);
    step(0, 1, 1, 6'h00, 6'h00, 5'd0, 0, 0, 32'h0);
`ifdef RETIRE_CNT_EN
    for (int i = 0; i < 17; i++) step(1, 1, 1, 6'h01, 6'h02, 5'd1, 0, 0, 32'h0);
    step(1, 0, 0, 6'h00, 6'h00, 5'd0, 0, 0, 32'h0);
    check("retire_cnt_sat", retire_cnt, 15);
    step(0, 0, 0, 6'h00, 6'h00, 5'd0, 0, 0, 32'h0);
`endif
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 40) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
           6'($urandom), 6'($urandom), (($urandom % 4) == 0) ? 5'd0 : 5'($urandom),
           ($urandom % 6) == 0, ($urandom % 30) == 0, $urandom);
    end
    step(1, 0, 0, 6'h00, 6'h00, 5'd0, 0, 0, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
